mul_seq_ctrl: RTL
=================

# mul_seq_ctrl

Sequencing controller for the board-level shift-add multiplier. It accepts a start request with two operands and latches them. It then runs exactly WIDTH add/shift iterations, either free-running at one per clock or one per debounced step pulse, and presents the product with a one-cycle done pulse. Its outputs (product, iteration count, state) feed the seven-segment display path.

## Interface
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits
- clock  in  1  system clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request to begin a multiplication; sampled only in IDLE
- step_mode  in  1  0 = auto (one iteration per clock), 1 = manual (one iteration per step pulse)
- step  in  1  single-cycle pulse from the debouncer; ignored unless step_mode=1 and state=RUN
- multiplicand  in  WIDTH  operand A; sampled only when start is accepted
- multiplier  in  WIDTH  operand B; sampled only when start is accepted
- busy  out  1  high in RUN and DONE
- done  out  1  high for exactly one cycle, in DONE
- result  out  2*WIDTH  last completed product; held until the next product completes
- iter  out  $clog2(WIDTH+1)  completed iterations of the current or last run
- state  out  2  FSM code, for debug and display

## Operation
- FSM states are IDLE=0, RUN=1 and DONE=2. Code 3 is illegal and recovers to IDLE on the next edge.
- IDLE with start=1:
  - mcand_sh <= zero-extended multiplicand
  - mplier_sh <= multiplier
  - acc <= 0
  - iter <= 0
  - next state RUN
- IDLE with start=0: hold all registers.
- RUN: an iteration fires when (step_mode==0) or (step_mode==1 && step==1). Each iteration does:
  - if mplier_sh[0], acc <= acc + mcand_sh
  - mcand_sh <= mcand_sh << 1
  - mplier_sh <= mplier_sh >> 1
  - iter <= iter + 1
- On the iteration that makes iter equal WIDTH:
  - result <= final acc value (including that iteration's add)
  - next state DONE
- RUN with no iteration firing: hold everything.
- DONE: done=1; next state IDLE unconditionally.
- Width rules:
  - acc and mcand_sh are 2*WIDTH bits.
  - The sum never overflows, since (2^W-1)^2 < 2^(2W).
  - iter saturates at WIDTH by construction.
- start in RUN or DONE is ignored and not queued.
- Operand changes after acceptance have no effect on the run.
- step_mode may change mid-run and takes effect on the same cycle it is sampled.
- step pulses arriving in IDLE or DONE are discarded.
- reset_n=0, including mid-run, on the next edge:
  - state=IDLE
  - acc=0, result=0, iter=0, shift registers=0
  - busy=0, done=0

## Timing
- Reset values: busy=0, done=0, result=0, iter=0, state=0.
- Let E0 be the edge where start is accepted. busy=1 from E0.
- Auto mode:
  - iterations occur at E1..E_WIDTH
  - DONE is entered at E_WIDTH; done=1 and result is valid in the cycle after E_WIDTH
  - IDLE is reached at E_WIDTH+1; a new start is accepted at E_WIDTH+2 at the earliest
- Manual mode: same sequence, with each iteration gated by a step pulse. Latency = the edge of the WIDTH-th step pulse + 1 cycle to done.
- done, busy and state are Moore outputs decoded from registered state. There is no combinational path from any input to any output.

## Structure
- Shared package mul_pkg:
  - state localparams ST_IDLE, ST_RUN, ST_DONE
  - 2-bit state width constant
- Sub-module mul_shift_add:
  - contains acc, mcand_sh and mplier_sh
  - inputs: load, iterate, operands
  - outputs: acc
- The mul_seq_ctrl top holds the FSM, the iter counter, step gating and the result register.

## Test plan
- Auto, WIDTH=4, 13×11 with start at E0 -> done pulse in the cycle after E4 only, result=8'h8F, iter=4, busy low after E5.
- Manual, 15×15 with 3 step pulses -> state stays RUN, iter=3, done=0. Fourth pulse -> result=8'hE1, one done pulse.
- 0×9, then 9×0 -> result=0 both times, and done still fires after exactly 4 iterations.
- start held high continuously, operands changed during RUN -> result uses operands latched at acceptance; next run starts at E6 (E_WIDTH+2), not in DONE.
- reset_n low for one edge during RUN at iter=2 -> next cycle state=IDLE, result=0, iter=0, busy=0, no done pulse.
- step pulses in IDLE, then start in manual mode -> iter=0 until the first post-start step; stale pulses are not counted.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller.
package mul_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add datapath: accumulator plus shifting multiplicand and multiplier registers.
module mul_shift_add #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 iterate,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   acc,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    // Value the accumulator takes if this cycle iterates; lets the top capture
    // the final product on the same edge as the last add.
    always_comb begin
        acc_next = acc_q;
        if (mplier_q[0]) begin
            acc_next = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_q <= multiplier;
        end else if (iterate) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller: start handshake, auto/manual iteration gating,
// iteration counter and held result register around the shift-add datapath.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    localparam int unsigned ITER_W = $clog2(WIDTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [ITER_W-1:0]    iter,
    output logic [STATE_W-1:0]   state
);

    mul_state_e          state_q, state_d;
    logic [ITER_W-1:0]   iter_q;
    logic [2*WIDTH-1:0]  result_q;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  acc_next;
    logic                load;
    logic                iterate;
    logic                last_iter;

    assign last_iter = (iter_q == ITER_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        iterate = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Step pulses only matter in manual mode; auto mode fires every cycle.
                if (!step_mode || step) begin
                    iterate = 1'b1;
                    if (last_iter) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            iter_q   <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                iter_q <= '0;
            end else if (iterate) begin
                iter_q <= iter_q + 1'b1;
                if (last_iter) begin
                    result_q <= acc_next;
                end
            end
        end
    end

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_shift_add (
        .clock        (clock),
        .reset_n      (reset_n),
        .load         (load),
        .iterate      (iterate),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .acc          (acc),
        .acc_next     (acc_next)
    );

    assign busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign iter   = iter_q;
    assign state  = state_q;

endmodule
